// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus and stalls the pipeline until the access completes.
// Optional MISALIGN_TRAP_EN: misaligned accesses complete at once with misalign=1 and never reach the bus.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_memRead,
  input  logic        in_memWrite,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        stall,
  output logic        misalign
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;

  logic        memop;
  logic        in_mis;
  logic [7:0]  rbyte [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  assign memop = in_valid & (in_memRead | in_memWrite) & ~flush;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   in_mis = 1'b0;
      2'b01:   in_mis = in_addr[0];
      default: in_mis = |in_addr[1:0];
    endcase
  end

  always_comb begin
    mis_d = mis_q;
    if (state_q == S_IDLE && memop) mis_d = in_mis;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign misalign = out_valid & mis_q;
`else
  assign in_mis   = 1'b0;
  assign misalign = 1'b0;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = dmem_rdata[8*gi +: 8];
  end

  // Load extraction; funct3[2] selects zero- instead of sign-extension.
  always_comb begin
    ld_byte = rbyte[addr_q[1:0]];
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_data = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          funct3_d = in_funct3;
          we_d     = in_memWrite;
          if (in_mis) begin
            state_d = S_DONE;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A read that was already granted must have its response drained.
        if (dmem_gnt) begin
          if (flush) state_d = we_q ? S_IDLE : S_DRAIN;
          else       state_d = we_q ? S_DONE : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = ld_data;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (dmem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wstrb = dmem_we ? st_strb : 4'b0000;
  assign dmem_wdata = st_data;
  assign out_valid  = (state_q == S_DONE) & ~flush;
  assign out_rdata  = rdata_q;

  // Stall is gated by reset so an in-flight instruction cannot hold the pipe during reset.
  always_comb begin
    case (state_q)
      S_IDLE:                  stall = memop;
      S_REQ, S_WAIT, S_DRAIN:  stall = 1'b1;
      default:                 stall = 1'b0;
    endcase
    stall = stall & ~reset;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: completions are checked against a scoreboard queue of expected results.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_memRead = 1'b0, in_memWrite = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic        flush = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid, stall, misalign;
  logic [31:0] out_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_load = '0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_memRead(in_memRead),
    .in_memWrite(in_memWrite), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata), .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Every completion pops the oldest expected result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_out_rdata", out_rdata, e.rdata);
        check("sb_misalign", 32'(misalign), 32'(e.mis));
        $display("txn complete: out_rdata=%h misalign=%0d", out_rdata, misalign);
      end
    end
  end

  // One full access with gw idle REQ cycles before gnt and rw idle WAIT cycles before rvalid.
  task automatic run_op(input string tag, input logic we, input logic rd_too,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int gw, input int rw, input logic [31:0] rdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                        input logic [31:0] exp_res);
    int   stalls;
    exp_t e;
    if (!we) last_load = exp_res;
    e.rdata = last_load;
    e.mis   = 1'b0;
    sb_q.push_back(e);
    nxt();
    in_valid = 1'b1; in_memRead = we ? rd_too : 1'b1; in_memWrite = we;
    in_funct3 = f3; in_addr = addr; in_wdata = wd;
    #2;
    stalls = int'(stall);
    check({tag, ":no_req_in_idle"}, 32'(dmem_req), 32'd0);
    for (int i = 0; i <= gw; i++) begin
      nxt();
      dmem_gnt = (i == gw);
      #2;
      stalls += int'(stall);
      check({tag, ":req_held"}, 32'(dmem_req), 32'd1);
    end
    check({tag, ":addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, ":we"}, 32'(dmem_we), 32'(we));
    check({tag, ":wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
    if (we) check({tag, ":wdata"}, dmem_wdata, exp_wd);
    if (!we) begin
      for (int j = 0; j <= rw; j++) begin
        nxt();
        dmem_gnt = 1'b0;
        dmem_rvalid = (j == rw);
        dmem_rdata = (j == rw) ? rdata : $urandom;
        #2;
        stalls += int'(stall);
      end
    end
    nxt();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #2;
    stalls += int'(stall);
    check({tag, ":done_valid"}, 32'(out_valid), 32'd1);
    check({tag, ":stall_cycles"}, 32'(stalls), we ? 32'(2 + gw) : 32'(3 + gw + rw));
    nxt();
    in_valid = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0;
    #2;
    check({tag, ":back_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":back_idle_req"}, 32'(dmem_req), 32'd0);
    $display("txn %s addr=%h stalls=%0d", tag, addr, stalls);
  endtask

  initial begin
    #2;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    nxt();
    reset = 1'b0;

    run_op("SW",    1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 4'hF, 32'hDEADBEEF, 32'h0);
    run_op("LB",    1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 0, 1, 32'h80FF0000, 4'h0, 32'h0, 32'hFFFFFF80);
    run_op("LBU",   1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 0, 1, 32'h80FF0000, 4'h0, 32'h0, 32'h00000080);
    run_op("SH",    1'b1, 1'b0, 3'b001, 32'h012, 32'h0000ABCD, 2, 0, 32'h0, 4'hC, 32'hABCDABCD, 32'h0);
    run_op("LH",    1'b0, 1'b0, 3'b001, 32'h012, 32'h0, 1, 0, 32'h80017FFF, 4'h0, 32'h0, 32'hFFFF8001);
    run_op("LHU",   1'b0, 1'b0, 3'b101, 32'h010, 32'h0, 0, 2, 32'h8001F00D, 4'h0, 32'h0, 32'h0000F00D);
    run_op("SB_rw", 1'b1, 1'b1, 3'b000, 32'h021, 32'h123456A5, 0, 0, 32'h0, 4'h2, 32'hA5A5A5A5, 32'h0);
    run_op("LWmis", 1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h12345678, 4'h0, 32'h0, 32'h12345678);
    run_op("LW011", 1'b0, 1'b0, 3'b011, 32'h046, 32'h0, 1, 0, 32'hCAFEF00D, 4'h0, 32'h0, 32'hCAFEF00D);

    // Flush in WAIT: drain the late response, keep the previous load result.
    nxt();
    in_valid = 1'b1; in_memRead = 1'b1; in_funct3 = 3'b010; in_addr = 32'h40;
    #2; check("fw:idle_stall", 32'(stall), 32'd1);
    nxt(); dmem_gnt = 1'b1;
    #2; check("fw:req", 32'(dmem_req), 32'd1);
    nxt(); dmem_gnt = 1'b0; flush = 1'b1; in_valid = 1'b0; in_memRead = 1'b0;
    #2; check("fw:wait_stall", 32'(stall), 32'd1); check("fw:wait_valid", 32'(out_valid), 32'd0);
    nxt(); flush = 1'b0;
    #2; check("fw:drain_stall1", 32'(stall), 32'd1); check("fw:drain_valid", 32'(out_valid), 32'd0);
    nxt();
    #2; check("fw:drain_stall2", 32'(stall), 32'd1);
    nxt(); dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
    #2; check("fw:drain_stall3", 32'(stall), 32'd1); check("fw:drain_valid3", 32'(out_valid), 32'd0);
    nxt(); dmem_rvalid = 1'b0;
    #2; check("fw:idle_stall", 32'(stall), 32'd0); check("fw:idle_valid", 32'(out_valid), 32'd0);
    check("fw:out_rdata_held", out_rdata, last_load);
    $display("txn flush_in_wait done");

    // Flush in REQ before gnt: request withdrawn, stray bus activity ignored.
    nxt(); in_valid = 1'b1; in_memRead = 1'b1; in_addr = 32'h50;
    nxt(); flush = 1'b1;
    #2; check("fr:req", 32'(dmem_req), 32'd1);
    nxt(); flush = 1'b0; in_valid = 1'b0; in_memRead = 1'b0; dmem_gnt = 1'b1;
    #2; check("fr:req_dropped", 32'(dmem_req), 32'd0); check("fr:stall", 32'(stall), 32'd0);
    nxt(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
    #2; check("fr:valid", 32'(out_valid), 32'd0);
    nxt(); dmem_rvalid = 1'b0;
    $display("txn flush_in_req done");

    // Flush in IDLE blocks launch.
    nxt(); in_valid = 1'b1; in_memWrite = 1'b1; flush = 1'b1; in_addr = 32'h60;
    #2; check("fi:stall", 32'(stall), 32'd0);
    nxt(); in_valid = 1'b0; in_memWrite = 1'b0; flush = 1'b0;
    #2; check("fi:req", 32'(dmem_req), 32'd0);
    $display("txn flush_in_idle done");

    // Flush in DONE suppresses completion.
    nxt(); in_valid = 1'b1; in_memWrite = 1'b1; in_funct3 = 3'b010; in_addr = 32'h30;
    nxt(); dmem_gnt = 1'b1;
    nxt(); dmem_gnt = 1'b0; flush = 1'b1;
    #2; check("fd:valid", 32'(out_valid), 32'd0); check("fd:stall", 32'(stall), 32'd0);
    nxt(); flush = 1'b0; in_valid = 1'b0; in_memWrite = 1'b0;
    #2; check("fd:valid_after", 32'(out_valid), 32'd0); check("fd:req_after", 32'(dmem_req), 32'd0);
    $display("txn flush_in_done done");

    // Reset in REQ abandons the access.
    nxt(); in_valid = 1'b1; in_memRead = 1'b1; in_addr = 32'h80;
    nxt();
    #2; check("rr:req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rr:req_zero", 32'(dmem_req), 32'd0);
    check("rr:stall_zero", 32'(stall), 32'd0);
    check("rr:out_rdata_zero", out_rdata, 32'd0);
    check("rr:wstrb_zero", 32'(dmem_wstrb), 32'd0);
    last_load = '0;
    nxt(); reset = 1'b0; in_valid = 1'b0; in_memRead = 1'b0; dmem_gnt = 1'b1;
    #2; check("rr:stray_gnt_req", 32'(dmem_req), 32'd0);
    nxt(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
    #2; check("rr:stray_rv_valid", 32'(out_valid), 32'd0); check("rr:stray_rv_stall", 32'(stall), 32'd0);
    nxt(); dmem_rvalid = 1'b0;
    #2; check("rr:idle_valid", 32'(out_valid), 32'd0); check("rr:out_rdata", out_rdata, 32'd0);
    $display("txn reset_in_req done");

    nxt();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
